multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main sequencing controller for the multicycle RV32I core: Moore FSM driving datapath selects.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes enter a TRAP state and raise illegal_instr.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [5:0] alu_cntrl,
    output logic       illegal_instr
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [5:0] AluAdd = 6'h00;
    localparam logic [5:0] AluSub = 6'h08;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal
`ifdef CTRL_ILLEGAL_TRAP_EN
        , StTrap
`endif
    } state_e;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_e StIllegal = StTrap;
`else
    // Unknown opcodes retire as a NOP: only the fetch's PC+4 has taken effect.
    localparam state_e StIllegal = StFetch;
`endif

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecR;
                    OpItype:         state_d = StExecI;
                    OpBranch:        state_d = (funct3[2:1] == 2'b00) ? StBranch : StIllegal;
                    OpJal:           state_d = StJal;
                    default:         state_d = StIllegal;
                endcase
            end
            StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJal:      state_d = StAluWb;
`ifdef CTRL_ILLEGAL_TRAP_EN
            StTrap:     state_d = StTrap;
`endif
            default:    state_d = StFetch;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q | ((state_q == StDecode) && (state_d == StTrap));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

    // Everything is held at 0 while reset is asserted, including the FETCH request.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        imm_src    = 3'b000;
        alu_cntrl  = AluAdd;
        if (rst_n) begin
            case (op)
                OpStore:  imm_src = 3'b001;
                OpBranch: imm_src = 3'b010;
                OpJal:    imm_src = 3'b011;
                default:  imm_src = 3'b000;
            endcase
            unique case (state_q)
                StFetch: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                StDecode: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                StMemAdr: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                StMemRead: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                StMemWb: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                StMemWrite: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                StExecR: begin
                    alu_src_a = 2'b10;
                    alu_cntrl = {2'b00, funct7b5, funct3};
                end
                StExecI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    // Only SRAI carries a meaningful funct7 bit among immediate ops.
                    alu_cntrl = {2'b00, funct7b5 & (funct3 == 3'b101), funct3};
                end
                StAluWb: begin
                    reg_write = 1'b1;
                end
                StBranch: begin
                    alu_src_a = 2'b10;
                    alu_cntrl = AluSub;
                    pc_write  = zero ^ funct3[0];
                end
                StJal: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, corner sequences and a randomized
// instruction stream checked against a per-instruction-class cycle model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b1;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [5:0] alu_cntrl;
    logic       illegal_instr;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_cntrl(alu_cntrl), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
        logic [1:0] result_src, a, b;
        logic [2:0] imm;
        logic [5:0] alu;
    } outs_t;

    outs_t dut_o;
    assign dut_o = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src,
                    alu_src_a, alu_src_b, imm_src, alu_cntrl};

    typedef enum int {CR, CI, CLD, CST, CBR, CJ, CILL} cls_e;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         cyc;
        logic [5:0] alu;
        logic       pcw;
        logic [2:0] imm;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic int len_of(input cls_e c);
        case (c)
            CLD:     return 5;
            CBR:     return 3;
            CILL:    return 2;
            default: return 4;
        endcase
    endfunction

    // Expected outputs on step s of an instruction of class c (wait cycles repeat a step).
    function automatic outs_t model(input cls_e c, input int s, input logic [6:0] o,
                                    input logic [2:0] f3, input logic f7, input logic z,
                                    input logic mr);
        outs_t e = '0;
        e.imm = imm_of(o);
        if (s == 0) begin
            e.mem_req = 1; e.b = 2'b10; e.result_src = 2'b10; e.ir_write = mr; e.pc_write = mr;
        end else if (s == 1) begin
            e.a = 2'b01; e.b = 2'b01;
        end else begin
            case (c)
                CR:  if (s == 2) begin e.a = 2'b10; e.alu = {2'b00, f7, f3}; end
                     else e.reg_write = 1;
                CI:  if (s == 2) begin
                         e.a = 2'b10; e.b = 2'b01; e.alu = {2'b00, f7 && f3 == 3'd5, f3};
                     end else e.reg_write = 1;
                CLD: if (s == 2) begin e.a = 2'b10; e.b = 2'b01; end
                     else if (s == 3) begin e.mem_req = 1; e.adr_src = 1; end
                     else begin e.result_src = 2'b01; e.reg_write = 1; end
                CST: if (s == 2) begin e.a = 2'b10; e.b = 2'b01; end
                     else begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; end
                CBR: begin e.a = 2'b10; e.alu = 6'h08; e.pc_write = z ^ f3[0]; end
                CJ:  if (s == 2) begin e.a = 2'b01; e.b = 2'b10; e.pc_write = 1; end
                     else e.reg_write = 1;
                default: ;
            endcase
        end
        return e;
    endfunction

    // Runs one instruction from its FETCH cycle, random waits on request cycles.
    task automatic run_instr(input cls_e c, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int max_wait);
        int  s = 0;
        int  w = 0;
        bit  waitph;
        op = o; funct3 = f3; funct7b5 = f7;
        while (s < len_of(c)) begin
            waitph = (s == 0) || ((c == CLD || c == CST) && s == 3);
            zero = 1'($urandom);
            mem_ready = (waitph && w >= max_wait) ? 1'b1 : 1'($urandom);
            #2;
            chk($sformatf("rand cls%0d step%0d", c, s), 32'(dut_o),
                32'(model(c, s, o, f3, f7, zero, mem_ready)));
            chk("rand illegal_instr", 32'(illegal_instr), 32'd0);
            if (!waitph || mem_ready) begin s++; w = 0; end
            else w++;
            tick();
        end
    endtask

    vec_t       vec[$];
    int         cyc, nrd, nwb;
    logic [5:0] alu2;
    logic       pcw2;
    logic [2:0] imm1;
    logic [1:0] rs;
    bit         done;
    cls_e       cls;
    logic [6:0] ro;
    logic [2:0] rf3;
    logic [6:0] ill_ops[4] = '{7'b1111111, 7'b0000000, 7'b0110111, 7'b1100011};

    initial begin
        //          op          f3     f7 z  cyc alu    pcw imm
        vec.push_back('{7'b0110011, 3'd0, 0, 0, 4, 6'h00, 0, 3'd0});
        vec.push_back('{7'b0110011, 3'd0, 1, 0, 4, 6'h08, 0, 3'd0});
        vec.push_back('{7'b0110011, 3'd5, 1, 1, 4, 6'h0D, 0, 3'd0});
        vec.push_back('{7'b0010011, 3'd0, 1, 0, 4, 6'h00, 0, 3'd0});
        vec.push_back('{7'b0010011, 3'd5, 1, 0, 4, 6'h0D, 0, 3'd0});
        vec.push_back('{7'b0010011, 3'd5, 0, 0, 4, 6'h05, 0, 3'd0});
        vec.push_back('{7'b0000011, 3'd2, 0, 0, 5, 6'h00, 0, 3'd0});
        vec.push_back('{7'b0100011, 3'd2, 0, 0, 4, 6'h00, 0, 3'd1});
        vec.push_back('{7'b1100011, 3'd0, 0, 1, 3, 6'h08, 1, 3'd2});
        vec.push_back('{7'b1100011, 3'd0, 0, 0, 3, 6'h08, 0, 3'd2});
        vec.push_back('{7'b1100011, 3'd1, 0, 0, 3, 6'h08, 1, 3'd2});
        vec.push_back('{7'b1100011, 3'd1, 0, 1, 3, 6'h08, 0, 3'd2});
        vec.push_back('{7'b1101111, 3'd7, 1, 0, 4, 6'h00, 1, 3'd3});
`ifndef CTRL_ILLEGAL_TRAP_EN
        vec.push_back('{7'b1111111, 3'd0, 0, 0, 2, 6'h00, 0, 3'd0});
`endif

        // Reset: everything 0, even across clock edges
        #2;
        chk("reset outs", 32'(dut_o), 32'd0);
        chk("reset illegal_instr", 32'(illegal_instr), 32'd0);
        repeat (2) tick();
        chk("reset outs after clocks", 32'(dut_o), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("first mem_req after release", 32'(mem_req), 32'd1);

        // Vector table, zero-wait memory
        for (int i = 0; i < vec.size(); i++) begin
            op = vec[i].op; funct3 = vec[i].f3; funct7b5 = vec[i].f7; zero = vec[i].z;
            mem_ready = 1'b1;
            cyc = 0; alu2 = '0; pcw2 = 1'b0; imm1 = '0; done = 0;
            while (!done) begin
                #2;
                if ((cyc > 0 && ir_write) || cyc > 20) begin
                    done = 1;
                end else begin
                    if (cyc == 1) imm1 = imm_src;
                    if (cyc == 2) begin alu2 = alu_cntrl; pcw2 = pc_write; end
                    tick();
                    cyc++;
                end
            end
            chk($sformatf("vec%0d cycles", i), 32'(cyc), 32'(vec[i].cyc));
            chk($sformatf("vec%0d imm_src", i), 32'(imm1), 32'(vec[i].imm));
            if (vec[i].cyc > 2) begin
                chk($sformatf("vec%0d alu_cntrl", i), 32'(alu2), 32'(vec[i].alu));
                chk($sformatf("vec%0d pc_write", i), 32'(pcw2), 32'(vec[i].pcw));
            end
        end

        // Load with three wait cycles in MEMREAD: 8 cycles total
        op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0;
        nrd = 0; nwb = 0; rs = 2'b11;
        for (int c = 0; c < 8; c++) begin
            mem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #2;
            if (mem_req && adr_src) nrd++;
            if (reg_write) begin nwb++; rs = result_src; end
            tick();
        end
        mem_ready = 1'b1;
        #2;
        chk("load read-request cycles", 32'(nrd), 32'd4);
        chk("load reg_write cycles", 32'(nwb), 32'd1);
        chk("load result_src", 32'(rs), 32'd1);
        chk("load refetch at cycle 8", 32'(ir_write), 32'd1);

        // Reset during a MEMWRITE wait aborts the store
        op = 7'b0100011; funct3 = 3'd2;
        for (int c = 0; c < 3; c++) tick();
        mem_ready = 1'b0;
        #2;
        chk("store mem_write in wait", 32'(mem_write), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset mem_write", 32'(mem_write), 32'd0);
        chk("async reset outs", 32'(dut_o), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        run_instr(CR, 7'b0110011, 3'd0, 1'b1, 2);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            cls = cls_e'($urandom_range(0, 5));
`else
            cls = cls_e'($urandom_range(0, 6));
`endif
            rf3 = 3'($urandom);
            case (cls)
                CR:  ro = 7'b0110011;
                CI:  ro = 7'b0010011;
                CLD: ro = 7'b0000011;
                CST: ro = 7'b0100011;
                CBR: begin ro = 7'b1100011; rf3 = 3'($urandom_range(0, 1)); end
                CJ:  ro = 7'b1101111;
                default: begin
                    ro = ill_ops[$urandom_range(0, 3)];
                    if (ro == 7'b1100011) rf3 = 3'($urandom_range(2, 7));
                end
            endcase
            run_instr(cls, ro, rf3, 1'($urandom), $urandom_range(0, 4));
        end

        // Illegal opcode handling
        op = 7'b1111111; funct3 = 3'd0; mem_ready = 1'b1;
        #2;
        tick();
        #2;
        chk("illegal decode flag", 32'(illegal_instr), 32'd0);
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int c = 0; c < 20; c++) begin
            mem_ready = 1'($urandom);
            #2;
            chk($sformatf("trap illegal_instr c%0d", c), 32'(illegal_instr), 32'd1);
            chk($sformatf("trap strobes c%0d", c),
                32'({mem_req, mem_write, ir_write, pc_write, reg_write}), 32'd0);
            tick();
        end
`else
        #2;
        chk("illegal nop next mem_req", 32'(mem_req), 32'd1);
        chk("illegal nop next adr_src", 32'(adr_src), 32'd0);
        chk("illegal nop next ir_write", 32'(ir_write), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
